// File: rtl/bcnn_filter_scheduler.sv
// bcnn_filter_scheduler
//
// Time-shares one external systolic_chain_3x3 XNOR-popcount datapath across
// NUM_FILTERS binary 3x3 filters. One 9-bit binarised patch is accepted per
// handshake. It is issued once per filter against that filter's stored weights,
// and each returned popcount is thresholded. The NUM_FILTERS result bits are
// packed into one output word for the next BCNN layer.
//
// Optional build macro: BCNN_SCHED_TIMEOUT_EN
//   When defined, a drain watchdog forces the packed result out after
//   TIMEOUT_CYCLES cycles in DRAIN. Bits not yet received stay 0 and err is
//   set. When undefined, DRAIN waits indefinitely.
//
// Ports
//   clk                in   system clock, all logic on posedge
//   reset              in   synchronous active-high reset
//   cfg_we             in   write filter config (honoured only in IDLE)
//   cfg_addr           in   filter index for the config write
//   cfg_weight         in   9 weight bits for filter cfg_addr
//   cfg_thresh         in   popcount threshold for filter cfg_addr
//   patch_valid        in   upstream patch available
//   patch_ready        out  scheduler accepts a patch
//   patch_data         in   binarised 3x3 patch
//   chain_valid_in     out  chain valid_in
//   chain_patch_bits   out  chain patch_bits
//   chain_weight_bits  out  chain weight_bits
//   chain_popcount     in   chain popcount
//   chain_valid_out    in   chain valid_out
//   out_valid          out  packed result valid
//   out_ready          in   downstream accepts the result
//   out_bits           out  bit k = result of filter k
//   busy               out  high in any state other than IDLE
//   err                out  sticky error flag, cleared only by reset
//
// State table
//   state | meaning
//   IDLE  | config writes allowed, waiting for a patch
//   ISSUE | one chain issue per cycle, filter 0..NUM_FILTERS-1
//   DRAIN | all issued, waiting for the remaining chain results
//   OUT   | packed word presented, waiting for out_ready

module bcnn_filter_scheduler #(
  parameter int NUM_FILTERS    = 8,
  parameter int SUM_WIDTH      = 4,
  parameter int FIDX_W         = $clog2(NUM_FILTERS),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [FIDX_W-1:0]      cfg_addr,
  input  logic [8:0]             cfg_weight,
  input  logic [SUM_WIDTH-1:0]   cfg_thresh,
  input  logic                   patch_valid,
  output logic                   patch_ready,
  input  logic [8:0]             patch_data,
  output logic                   chain_valid_in,
  output logic [8:0]             chain_patch_bits,
  output logic [8:0]             chain_weight_bits,
  input  logic [SUM_WIDTH-1:0]   chain_popcount,
  input  logic                   chain_valid_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_FILTERS-1:0] out_bits,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FILTERS - 1);
  localparam logic [FIDX_W:0]   RX_FULL  = (FIDX_W + 1)'(NUM_FILTERS);

  state_t state;
  state_t state_next;

  logic [8:0]           weight [NUM_FILTERS];
  logic [SUM_WIDTH-1:0] thresh [NUM_FILTERS];

  logic [FIDX_W-1:0] issue_cnt;
  logic [FIDX_W-1:0] issue_nxt;
  // One bit wider than a filter index so that "all received" is representable.
  logic [FIDX_W:0]   rx_cnt;
  logic [FIDX_W-1:0] rx_idx;

  logic accept;
  logic cfg_hit;
  logic cfg_drop;
  logic rx_done;
  logic rx_take;
  logic rx_stray;
  logic rx_bit;
  logic timeout;

  assign issue_nxt = issue_cnt + 1'b1;
  assign rx_idx    = rx_cnt[FIDX_W-1:0];
  assign rx_done   = (rx_cnt == RX_FULL);
  assign accept    = patch_valid && patch_ready;
  assign cfg_hit   = cfg_we && (state == IDLE) && (32'(cfg_addr) < NUM_FILTERS);
  assign cfg_drop  = cfg_we && (state != IDLE);

  // Results are matched to filters purely by arrival order, so only
  // ISSUE/DRAIN with room left can take one. Anything else is a protocol fault.
  assign rx_take  = chain_valid_out && ((state == ISSUE) || (state == DRAIN)) && !rx_done;
  assign rx_stray = chain_valid_out && !rx_take;
  assign rx_bit   = (chain_popcount >= thresh[rx_idx]);

`ifdef BCNN_SCHED_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Down-counter reloaded outside DRAIN; terminal count on the
  // TIMEOUT_CYCLES-th DRAIN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != DRAIN) begin
      wd_cnt <= WD_LOAD;
    end else if (wd_cnt != '0) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign timeout = (state == DRAIN) && (wd_cnt == '0) && !rx_done;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    patch_ready = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        // A config write owns the cycle; reset masks the combinational ready.
        patch_ready = !cfg_we && !reset;
        if (patch_valid && patch_ready) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt == LAST_IDX) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_done || timeout) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      chain_valid_in    <= 1'b0;
      chain_patch_bits  <= '0;
      chain_weight_bits <= '0;
      out_bits          <= '0;
      err               <= 1'b0;
      issue_cnt         <= '0;
      rx_cnt            <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        weight[i] <= '0;
        thresh[i] <= '0;
      end
    end else begin
      state <= state_next;

      if (cfg_hit) begin
        weight[cfg_addr] <= cfg_weight;
        thresh[cfg_addr] <= cfg_thresh;
      end

      if (cfg_drop || rx_stray || timeout) begin
        err <= 1'b1;
      end

      // chain_patch_bits doubles as the latched patch for the whole issue run.
      if (accept) begin
        chain_valid_in    <= 1'b1;
        chain_patch_bits  <= patch_data;
        chain_weight_bits <= weight[0];
        issue_cnt         <= '0;
        rx_cnt            <= '0;
        out_bits          <= '0;
      end else if (state == ISSUE) begin
        if (issue_cnt == LAST_IDX) begin
          chain_valid_in    <= 1'b0;
          chain_weight_bits <= '0;
        end else begin
          issue_cnt         <= issue_nxt;
          chain_weight_bits <= weight[issue_nxt];
        end
      end

      if (rx_take) begin
        out_bits[rx_idx] <= rx_bit;
        rx_cnt           <= rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcnn_filter_scheduler.sv
module tb_bcnn_filter_scheduler;

  localparam int NF  = 8;
  localparam int SW  = 4;
  localparam int FW  = 3;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [FW-1:0] cfg_addr = '0;
  logic [8:0]    cfg_weight = '0;
  logic [SW-1:0] cfg_thresh = '0;
  logic          patch_valid = 1'b0;
  logic          patch_ready;
  logic [8:0]    patch_data = '0;
  logic          chain_valid_in;
  logic [8:0]    chain_patch_bits;
  logic [8:0]    chain_weight_bits;
  logic [SW-1:0] chain_popcount;
  logic          chain_valid_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NF-1:0] out_bits;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [NF-1:0] exp_q[$];

  always #5 clk = ~clk;

  bcnn_filter_scheduler #(.NUM_FILTERS(NF), .SUM_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight), .cfg_thresh(cfg_thresh),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_data(patch_data),
    .chain_valid_in(chain_valid_in), .chain_patch_bits(chain_patch_bits),
    .chain_weight_bits(chain_weight_bits), .chain_popcount(chain_popcount),
    .chain_valid_out(chain_valid_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .busy(busy), .err(err)
  );

  // Fixed-latency XNOR-popcount chain model; not reset, so in-flight results
  // survive a scheduler reset.
  logic [LAT-1:0] pipe_v = '0;
  logic [SW-1:0]  pipe_c [LAT];
  logic           kill_chain = 1'b0;

  function automatic logic [SW-1:0] pc9(input logic [8:0] v);
    return SW'($countones(v));
  endfunction

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], chain_valid_in};
    pipe_c[0] <= pc9(~(chain_patch_bits ^ chain_weight_bits));
    for (int i = 1; i < LAT; i++) pipe_c[i] <= pipe_c[i-1];
  end

  assign chain_valid_out = pipe_v[LAT-1] && !kill_chain;
  assign chain_popcount  = pipe_c[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_bits), 32'hDEAD);
      end else begin
        check("out_bits", 32'(out_bits), 32'(exp_q.pop_front()));
      end
    end
  end

  // Every issue run must be exactly NF cycles with no overlap.
  int run_len = 0;
  bit run_chk_en = 1'b1;
  always @(negedge clk) begin
    if (chain_valid_in) begin
      run_len++;
    end else if (run_len != 0) begin
      if (run_chk_en) check("civ_run_len", 32'(run_len), 32'(NF));
      run_len = 0;
    end
  end

  task automatic cfg_write(input int a, input logic [8:0] w, input logic [SW-1:0] t);
    cfg_we = 1'b1; cfg_addr = FW'(a); cfg_weight = w; cfg_thresh = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_patch(input logic [8:0] p, input logic [NF-1:0] e);
    int n = 0;
    exp_q.push_back(e);
    patch_valid = 1'b1; patch_data = p;
    @(negedge clk);
    while (!patch_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("patch_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    patch_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_patch_ready", 32'(patch_ready), 0);
    check("rst_civ", 32'(chain_valid_in), 0);
    check("rst_patch_bits", 32'(chain_patch_bits), 0);
    check("rst_weight_bits", 32'(chain_weight_bits), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_bits", 32'(out_bits), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(patch_ready), 1);

    // All filters all-ones weight, thresh 5; patch popcount 5 -> all ones
    for (int k = 0; k < NF; k++) cfg_write(k, 9'h1FF, 4'd5);
    send_patch(9'b101010101, 8'hFF);
    @(negedge clk);
    check("busy_in_issue", 32'(busy), 1);
    wait_drain();
    check("err_after_t1", 32'(err), 0);

    // Thresh k+3, patch popcount 5 -> filters 0..2 pass
    for (int k = 0; k < NF; k++) cfg_write(k, 9'h1FF, SW'(k + 3));
    send_patch(9'b000011111, 8'b00000111);
    wait_drain();

    // Downstream stall for 10 cycles
    out_ready = 1'b0;
    send_patch(9'b000011111, 8'b00000111);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      check("stall_reach_out", 32'(out_valid), 1);
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_out_bits", 32'(out_bits), 32'h07);
      check("stall_patch_ready", 32'(patch_ready), 0);
      check("stall_civ", 32'(chain_valid_in), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_ready", 32'(patch_ready), 1);
    check("release_busy", 32'(busy), 0);
    exp_q.push_back(8'b00000111);
    patch_valid = 1'b1; patch_data = 9'b000011111;
    @(posedge clk); #1 patch_valid = 1'b0;
    @(negedge clk);
    check("accept_next_cycle", 32'(busy), 1);
    wait_drain();

    // Config write during ISSUE is dropped and flags err
    send_patch(9'b000011111, 8'b00000111);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_weight = 9'h000; cfg_thresh = 4'd15;
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_in_issue_err", 32'(err), 1);
    wait_drain();

    // Back-to-back patches, out_ready held high
    send_patch(9'h1FF, 8'h7F);
    send_patch(9'h000, 8'h00);
    send_patch(9'b000011111, 8'b00000111);
    wait_drain();
    check("err_sticky", 32'(err), 1);

    // Threshold boundaries: thresh 0 always passes, thresh 10 never passes
    cfg_write(0, 9'h000, 4'd0);
    cfg_write(1, 9'h1FF, 4'd10);
    cfg_write(2, 9'h1FF, 4'd9);
    send_patch(9'h1FF, 8'h7D);
    wait_drain();

    // Reset two cycles into ISSUE
    run_chk_en = 1'b0;
    patch_valid = 1'b1; patch_data = 9'h0AA;
    @(posedge clk); #1 patch_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_civ", 32'(chain_valid_in), 0);
    check("midrst_patch_bits", 32'(chain_patch_bits), 0);
    check("midrst_weight_bits", 32'(chain_weight_bits), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_patch_ready", 32'(patch_ready), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("late_result_err", 32'(err), 1);
    check("late_result_idle", 32'(busy), 0);
    run_chk_en = 1'b1;
    for (int k = 0; k < NF; k++) cfg_write(k, 9'h1FF, 4'd5);
    send_patch(9'b101010101, 8'hFF);
    wait_drain();

`ifdef BCNN_SCHED_TIMEOUT_EN
    // Chain never answers: watchdog forces a zero result out
    do_reset(2);
    @(negedge clk);
    check("wd_err_clear", 32'(err), 0);
    for (int k = 0; k < NF; k++) cfg_write(k, 9'h1FF, 4'd0);
    kill_chain = 1'b1;
    send_patch(9'h1FF, 8'h00);
    wait_drain();
    check("wd_err_set", 32'(err), 1);
    kill_chain = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
